// File: rtl/add_pkg.sv
// Shared types and constants for the 32-bit parallel-prefix adder.
// Optional feature macro: ADD32_OVF_EN adds a signed-overflow flag to add_res_t.
package add_pkg;

    localparam int ADD_W     = 32;
    localparam int ADD_TAG_W = 4;

    localparam logic [1:0] KGP_KILL = 2'b00;
    localparam logic [1:0] KGP_GEN  = 2'b11;

    typedef struct packed {
        logic [ADD_W-1:0]     sum;
        logic                 cout;
        logic                 zero;
`ifdef ADD32_OVF_EN
        logic                 ovf;
`endif
        logic [ADD_TAG_W-1:0] tag;
    } add_res_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_FULL  = 2'b10
    } skid_state_t;

endpackage

// File: rtl/add_32_skid_buf.sv
// Two-entry valid/ready skid buffer over add_res_t.
// Main register m drives the outputs; skid register s catches the one op that
// can arrive in the cycle the consumer stalls. in_ready depends only on state.
//
// state      | meaning
// -----------+------------------------------------------
// SKID_EMPTY | m and s invalid
// SKID_ONE   | m valid, s invalid
// SKID_FULL  | m and s valid, upstream stalled
module add_32_skid_buf
    import add_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     in_valid,
    output logic     in_ready,
    input  add_res_t in_data,
    output logic     out_valid,
    input  logic     out_ready,
    output add_res_t out_data
);

    skid_state_t state;
    skid_state_t state_nxt;
    add_res_t    m;
    add_res_t    s;
    logic        accept;
    logic        pop;
    logic        load_m;
    logic        load_s;
    logic        take_skid;

    assign in_ready  = (state != SKID_FULL);
    assign out_valid = (state != SKID_EMPTY);
    assign out_data  = m;
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // State register and storage; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SKID_EMPTY;
            m     <= '0;
            s     <= '0;
        end else begin
            state <= state_nxt;
            if (load_m) begin
                m <= take_skid ? s : in_data;
            end
            if (load_s) begin
                s <= in_data;
            end
        end
    end

    // Next state and register load enables from the two handshakes.
    always_comb begin
        state_nxt = state;
        load_m    = 1'b0;
        load_s    = 1'b0;
        take_skid = 1'b0;
        case (state)
            SKID_EMPTY: begin
                if (accept) begin
                    state_nxt = SKID_ONE;
                    load_m    = 1'b1;
                end
            end
            SKID_ONE: begin
                if (accept && !pop) begin
                    state_nxt = SKID_FULL;
                    load_s    = 1'b1;
                end else if (accept && pop) begin
                    load_m    = 1'b1;
                end else if (pop) begin
                    state_nxt = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (pop) begin
                    state_nxt = SKID_ONE;
                    load_m    = 1'b1;
                    take_skid = 1'b1;
                end
            end
            default: begin
                state_nxt = SKID_EMPTY;
            end
        endcase
    end

endmodule

// File: rtl/add_32_sum_stage.sv
// Final stage of the 32-bit parallel-prefix adder: forms sum, carry-out and
// zero flag from the kgp and resolved carry vectors, then registers them in a
// skid buffer so the writeback path can backpressure without losing ops.
// Optional feature macro: ADD32_OVF_EN adds the signed-overflow output ovf.
module add_32_sum_stage
    import add_pkg::*;
#(
    parameter int W     = ADD_W,
    parameter int TAG_W = ADD_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*W-1:0]   kgp,
    input  logic [2*W-1:0]   temp_5,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     sum,
    output logic             cout,
    output logic             zero,
`ifdef ADD32_OVF_EN
    output logic             ovf,
`endif
    output logic [TAG_W-1:0] out_tag
);

    logic [W-1:0] prop;
    logic [W-1:0] carry;
    logic [W-1:0] carry_lo;
    logic [W-1:0] sum_bits;
    logic         unused_carry_lo;
    add_res_t     res;
    add_res_t     res_q;

    // Per-bit propagate and carry-in; the chain is seeded with no carry.
    always_comb begin
        prop     = '0;
        carry    = '0;
        carry_lo = '0;
        for (int i = 0; i < W; i++) begin
            prop[i]     = kgp[2*i] ^ kgp[2*i+1];
            carry_lo[i] = temp_5[2*i];
        end
        for (int i = 1; i < W; i++) begin
            carry[i] = temp_5[2*i-1];
        end
    end

    // The low bit of each resolved carry pair duplicates the high bit.
    assign unused_carry_lo = ^carry_lo;

    assign sum_bits = prop ^ carry;

    // Pack the result word that travels through the buffer.
    always_comb begin
        res      = '0;
        res.sum  = sum_bits;
        res.cout = temp_5[2*W-1];
        res.zero = ~|sum_bits;
`ifdef ADD32_OVF_EN
        res.ovf  = carry[W-1] ^ temp_5[2*W-1];
`endif
        res.tag  = in_tag;
    end

    add_32_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (res_q)
    );

    assign sum     = res_q.sum;
    assign cout    = res_q.cout;
    assign zero    = res_q.zero;
`ifdef ADD32_OVF_EN
    assign ovf     = res_q.ovf;
`endif
    assign out_tag = res_q.tag;

endmodule

// File: tb/tb_add_32_sum_stage.sv
// Directed and random-handshake bench for add_32_sum_stage.
module tb_add_32_sum_stage;

    localparam int W  = 32;
    localparam int TW = 4;
    localparam int N_RND = 10000;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2*W-1:0]  kgp;
    logic [2*W-1:0]  temp_5;
    logic [TW-1:0]   in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    sum;
    logic            cout;
    logic            zero;
`ifdef ADD32_OVF_EN
    logic            ovf;
`endif
    logic [TW-1:0]   out_tag;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    add_32_sum_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .kgp       (kgp),
        .temp_5    (temp_5),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .zero      (zero),
`ifdef ADD32_OVF_EN
        .ovf       (ovf),
`endif
        .out_tag   (out_tag)
    );

    // Stimulus generation: kgp pair i = {a_i, b_i}, temp_5 pair i = carry out of bit i.
    function automatic logic [2*W-1:0] f_kgp(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            r[2*i+1] = a[i];
            r[2*i]   = b[i];
        end
        return r;
    endfunction

    function automatic logic [2*W-1:0] f_carry(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] r;
        logic           c;
        r = '0;
        c = 1'b0;
        for (int i = 0; i < W; i++) begin
            c = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
            r[2*i+1] = c;
            r[2*i]   = c;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] t, input logic v);
        kgp      = f_kgp(a, b);
        temp_5   = f_carry(a, b);
        in_tag   = t;
        in_valid = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] q[$];
    logic [63:0] exp_w;
    logic [W:0]  wide;
    logic [W-1:0] ra, rb;
    logic [TW-1:0] rt;
    logic        acc_prev;
    int          sent, got, cyc;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        kgp       = '0;
        temp_5    = '0;
        in_tag    = '0;
        tick();
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_sum",       64'(sum),       64'd0);
        chk("rst_flags",     64'({cout, zero, out_tag}), 64'd0);
        rst = 1'b0;

        // 0xFFFFFFFF + 1
        out_ready = 1'b1;
        drive(32'hFFFF_FFFF, 32'h1, 4'h3, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_sum",   64'(sum),       64'h0);
        chk("t1_cout",  64'(cout),      64'd1);
        chk("t1_zero",  64'(zero),      64'd1);
        chk("t1_tag",   64'(out_tag),   64'h3);
`ifdef ADD32_OVF_EN
        chk("t1_ovf",   64'(ovf),       64'd0);
`endif

        // 0x7FFFFFFF + 1
        drive(32'h7FFF_FFFF, 32'h1, 4'h5, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t2_sum",   64'(sum),       64'h8000_0000);
        chk("t2_cout",  64'(cout),      64'd0);
        chk("t2_zero",  64'(zero),      64'd0);
        chk("t2_tag",   64'(out_tag),   64'h5);
`ifdef ADD32_OVF_EN
        chk("t2_ovf",   64'(ovf),       64'd1);
`endif
        tick();
        chk("t2_drained", 64'(out_valid), 64'd0);

        // back-to-back: a = i*0x11111111, b = i + 0x100
        for (int i = 0; i < 9; i++) begin
            if (i < 8) drive(32'(i) * 32'h1111_1111, 32'(i) + 32'h100, 4'(i), 1'b1);
            else in_valid = 1'b0;
            tick();
            if (i < 8) begin
                chk("t3_valid", 64'(out_valid), 64'd1);
                chk("t3_tag",   64'(out_tag),   64'(i));
                chk("t3_sum",   64'(sum),       64'(32'(i) * 32'h1111_1112 + 32'h100));
            end else begin
                chk("t3_end_valid", 64'(out_valid), 64'd0);
            end
        end

        // backpressure: 4 cycles of in_valid with out_ready low
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(32'h10 * 32'(i), 32'h1, 4'(8 + i), 1'b1);
            tick();
            chk("t4_in_ready", 64'(in_ready), (i == 0) ? 64'd1 : 64'd0);
            chk("t4_hold_tag", 64'(out_tag), 64'h8);
            chk("t4_hold_sum", 64'(sum), 64'h1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t4_drain1_tag", 64'(out_tag), 64'h9);
        chk("t4_drain1_sum", 64'(sum), 64'h11);
        chk("t4_drain1_rdy", 64'(in_ready), 64'd1);
        tick();
        chk("t4_drain2_valid", 64'(out_valid), 64'd0);
        drive(32'hFFFF_FFFE, 32'h1, 4'hC, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t4_resume_tag", 64'(out_tag), 64'hC);
        chk("t4_resume_sum", 64'({sum, cout, zero}), {30'd0, 32'hFFFF_FFFF, 2'b00});
        tick();

        // reset while full, with in_valid high during reset
        out_ready = 1'b0;
        drive(32'h5, 32'h6, 4'hA, 1'b1);
        tick();
        drive(32'h7, 32'h8, 4'hB, 1'b1);
        tick();
        chk("t5_full", 64'(in_ready), 64'd0);
        rst = 1'b1;
        tick();
        chk("t5_valid", 64'(out_valid), 64'd0);
        chk("t5_ready", 64'(in_ready),  64'd1);
        chk("t5_sum",   64'(sum),       64'd0);
        chk("t5_tag",   64'(out_tag),   64'd0);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_no_stale", 64'(out_valid), 64'd0);
        end

        // random handshakes, scoreboarded against a+b
        sent = 0;
        got  = 0;
        cyc  = 0;
        acc_prev = 1'b0;
        in_valid = 1'b0;
        while (got < N_RND && cyc < 80000) begin
            if (!in_valid || acc_prev) begin
                if (sent < N_RND && $urandom_range(0, 3) != 0) begin
                    ra = $urandom;
                    rb = $urandom;
                    if ($urandom_range(0, 15) == 0) rb = -ra;
                    if ($urandom_range(0, 15) == 0) ra = 32'hFFFF_FFFF;
                    rt = 4'($urandom);
                    drive(ra, rb, rt, 1'b1);
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #4;
            acc_prev = in_valid && in_ready;
            if (acc_prev) begin
                wide  = {1'b0, ra} + {1'b0, rb};
                exp_w = {26'd0, wide[W-1:0], wide[W], (wide[W-1:0] == '0), rt};
                q.push_back(exp_w);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious", 64'd1, 64'd0);
                end else begin
                    chk("rnd_result", {26'd0, sum, cout, zero, out_tag}, q.pop_front());
                end
                got++;
            end
            tick();
            cyc++;
        end
        chk("rnd_count", 64'(got), 64'(N_RND));
        chk("rnd_leftover", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
